// File: rtl/mux_nx1_hs.sv
// mux_nx1_hs: N-to-1 valid/ready multiplexer with a single registered output
// stage. MODE 0 steers by the external sel port, MODE 1 arbitrates
// round-robin starting after the last served channel.

// Per-channel ready generation: a channel is ready only when it holds the
// grant and the output register can take a word this cycle.
module mux_nx1_hs_lane #(
  parameter int SELW = 2,
  parameter int IDX  = 0
) (
  input  logic            load_en,
  input  logic            gnt_vld,
  input  logic [SELW-1:0] gnt_idx,
  output logic            ready
);

  assign ready = load_en & gnt_vld & (gnt_idx == SELW'(IDX));

endmodule

module mux_nx1_hs #(
  parameter  int N    = 4,
  parameter  int W    = 8,
  parameter  int MODE = 0,
  localparam int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  input  logic [SELW-1:0] sel,
  output logic [W-1:0]    out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SELW-1:0] out_chan
);

  logic [W-1:0]    out_data_q, out_data_d;
  logic [SELW-1:0] out_chan_q, out_chan_d;
  logic            out_valid_q, out_valid_d;
  logic [SELW-1:0] ptr_q, ptr_d;

  logic            load_en;
  logic            gnt_vld;
  logic [SELW-1:0] gnt_idx;
  logic            sel_vld;
  logic            rr_found;
  logic [SELW-1:0] rr_idx;
  logic            xfer;
  logic [W-1:0]    gnt_data;

  // Register is loadable when empty or draining; reset forces it closed so
  // no channel sees ready while rst is high.
  assign load_en = ~rst & (~out_valid_q | out_ready);

  // Fixed-select grant: sel codes at or above N grant nothing. The loop keeps
  // the in_valid lookup inside range for non-power-of-two N.
  always_comb begin
    sel_vld = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i == int'(sel)) sel_vld = in_valid[i];
    end
  end

  // Round-robin search starting one past the pointer, wrapping N-1 -> 0.
  always_comb begin
    int c;
    rr_found = 1'b0;
    rr_idx   = ptr_q;
    c        = 0;
    for (int k = 1; k <= N; k++) begin
      c = int'(ptr_q) + k;
      if (c >= N) c = c - N;
      if (!rr_found && in_valid[c]) begin
        rr_found = 1'b1;
        rr_idx   = SELW'(c);
      end
    end
  end

  // Mode select for the grant; MODE is constant so only one path remains.
  always_comb begin
    if (MODE == 1) begin
      gnt_idx = rr_idx;
      gnt_vld = |in_valid;
    end else begin
      gnt_idx = sel;
      gnt_vld = sel_vld;
    end
  end

  // One ready-generation lane per input channel.
  for (genvar g = 0; g < N; g++) begin : g_lane
    mux_nx1_hs_lane #(.SELW(SELW), .IDX(g)) u_lane (
      .load_en (load_en),
      .gnt_vld (gnt_vld),
      .gnt_idx (gnt_idx),
      .ready   (in_ready[g])
    );
  end

  assign xfer = load_en & gnt_vld;

  // Data steering from the granted channel; a loop avoids out-of-range
  // part-selects when gnt_idx holds an unused code.
  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (i == int'(gnt_idx)) gnt_data = in_data[i*W +: W];
    end
  end

  // Next state: load on transfer, drop valid on drain without refill,
  // otherwise hold. Pointer advances only on a completed transfer.
  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_data_d  = gnt_data;
      out_chan_d  = gnt_idx;
      out_valid_d = 1'b1;
      if (MODE == 1) ptr_d = gnt_idx;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register and arbitration pointer; pointer resets to N-1 so the
  // first round-robin search begins at channel 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= SELW'(N - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_nx1_hs.sv
// Directed bench for mux_nx1_hs: four instances cover N=4/N=3 in both modes.
module tb_mux_nx1_hs;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // u0: N=4 MODE 0
  logic [31:0] d0;  logic [3:0] v0, r0;  logic [1:0] s0;
  logic [7:0]  od0; logic ov0, or0;      logic [1:0] oc0;
  // u1: N=4 MODE 1
  logic [31:0] d1;  logic [3:0] v1, r1;  logic [1:0] s1;
  logic [7:0]  od1; logic ov1, or1;      logic [1:0] oc1;
  // u2: N=3 MODE 1
  logic [23:0] d2;  logic [2:0] v2, r2;  logic [1:0] s2;
  logic [7:0]  od2; logic ov2, or2;      logic [1:0] oc2;
  // u3: N=3 MODE 0
  logic [23:0] d3;  logic [2:0] v3, r3;  logic [1:0] s3;
  logic [7:0]  od3; logic ov3, or3;      logic [1:0] oc3;

  mux_nx1_hs #(.N(4), .W(8), .MODE(0)) u0 (
    .clk(clk), .rst(rst), .in_data(d0), .in_valid(v0), .in_ready(r0), .sel(s0),
    .out_data(od0), .out_valid(ov0), .out_ready(or0), .out_chan(oc0));
  mux_nx1_hs #(.N(4), .W(8), .MODE(1)) u1 (
    .clk(clk), .rst(rst), .in_data(d1), .in_valid(v1), .in_ready(r1), .sel(s1),
    .out_data(od1), .out_valid(ov1), .out_ready(or1), .out_chan(oc1));
  mux_nx1_hs #(.N(3), .W(8), .MODE(1)) u2 (
    .clk(clk), .rst(rst), .in_data(d2), .in_valid(v2), .in_ready(r2), .sel(s2),
    .out_data(od2), .out_valid(ov2), .out_ready(or2), .out_chan(oc2));
  mux_nx1_hs #(.N(3), .W(8), .MODE(0)) u3 (
    .clk(clk), .rst(rst), .in_data(d3), .in_valid(v3), .in_ready(r3), .sel(s3),
    .out_data(od3), .out_valid(ov3), .out_ready(or3), .out_chan(oc3));

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  int exp_a [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int exp_b [4] = '{1, 3, 1, 3};
  int exp_c [4] = '{0, 1, 2, 0};

  initial begin
    rst = 1'b1;
    d0 = '0; v0 = '0; s0 = '0; or0 = 1'b0;
    d1 = '0; v1 = '0; s1 = '0; or1 = 1'b0;
    d2 = '0; v2 = '0; s2 = '0; or2 = 1'b0;
    d3 = '0; v3 = '0; s3 = '0; or3 = 1'b0;
    #1;
    chk("rst_valid", ov0, 0);
    chk("rst_data",  od0, 0);
    tick();
    rst = 1'b0;

    // 1. Reset mid-cycle while a word is held
    s0 = 2; v0 = 4'b0100; d0 = 32'h00A5_0000; or0 = 1'b0;
    #1;
    chk("t1_ready_pre", r0, 4'b0100);
    tick();
    chk("t1_held_valid", ov0, 1);
    chk("t1_held_data",  od0, 8'hA5);
    or0 = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("t1_rst_valid", ov0, 0);
    chk("t1_rst_data",  od0, 0);
    chk("t1_rst_chan",  oc0, 0);
    chk("t1_rst_ready", r0, 4'b0000);
    #1 rst = 1'b0;
    v0 = 4'b0000;
    tick();
    tick();
    chk("t1_idle_valid", ov0, 0);
    chk("t1_idle_data",  od0, 0);
    chk("t1_idle_chan",  oc0, 0);

    // 2. MODE 0 steering
    s0 = 2; v0 = 4'b0100; d0 = 32'h00A5_0000; or0 = 1'b1;
    #1;
    chk("t2_ready", r0, 4'b0100);
    tick();
    chk("t2_data",  od0, 8'hA5);
    chk("t2_chan",  oc0, 2);
    chk("t2_valid", ov0, 1);
    s0 = 1; v0 = 4'b0000;
    #1;
    chk("t2_ready_none", r0, 4'b0000);
    tick();
    chk("t2_drain_valid", ov0, 0);
    chk("t2_drain_data",  od0, 8'hA5);

    // 3. Backpressure then no-bubble reload
    s0 = 0; v0 = 4'b0001; d0 = 32'h7700_003C; or0 = 1'b0;
    tick();
    chk("t3_load_data", od0, 8'h3C);
    v0 = 4'b1111; s0 = 3;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_stall_ready", r0, 4'b0000);
      tick();
      chk("t3_stall_data",  od0, 8'h3C);
      chk("t3_stall_valid", ov0, 1);
      chk("t3_stall_chan",  oc0, 0);
    end
    or0 = 1'b1;
    #1;
    chk("t3_release_ready", r0, 4'b1000);
    tick();
    chk("t3_next_data",  od0, 8'h77);
    chk("t3_next_chan",  oc0, 3);
    chk("t3_next_valid", ov0, 1);

    // 4. MODE 1 fairness
    do_rst();
    d1 = 32'h1312_1110; v1 = 4'b1111; or1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("t4_ready", r1, 32'd1 << exp_a[i]);
      tick();
      chk("t4_chan", oc1, exp_a[i]);
      chk("t4_data", od1, 8'h10 + exp_a[i]);
    end
    v1 = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_sparse_chan", oc1, exp_b[i]);
    end

    // 5. N=3 wrap and out-of-range sel
    do_rst();
    d2 = 24'h22_2120; v2 = 3'b111; or2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_chan", oc2, exp_c[i]);
      chk("t5_data", od2, 8'h20 + exp_c[i]);
    end
    s3 = 3; v3 = 3'b111; d3 = 24'h33_3231; or3 = 1'b1;
    #1;
    chk("t5_sel3_ready", r3, 3'b000);
    tick();
    chk("t5_sel3_valid", ov3, 0);

    // 6. Pointer holds across idle cycles
    do_rst();
    v1 = 4'b0010; or1 = 1'b1;
    tick();
    chk("t6_first_chan", oc1, 1);
    v1 = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t6_idle_ready", r1, 4'b0000);
      tick();
    end
    chk("t6_idle_valid", ov1, 0);
    v1 = 4'b1111;
    #1;
    chk("t6_resume_ready", r1, 4'b0100);
    tick();
    chk("t6_resume_chan", oc1, 2);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
